// File: rtl/chip_top_pkg.sv
// Shared types and defaults for the UART-to-SPI bridge.
package chip_top_pkg;
  localparam int DEF_CLK_PER_BIT = 1736;
  localparam int DEF_SPI_HALF    = 4;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    SPI_IDLE, SPI_SETUP, SPI_SHIFT, SPI_HOLD, SPI_GAP
  } spi_state_e;
endpackage

// File: rtl/chip_top_if.sv
// Byte handshake between the UART holders and the SPI shifter.
interface chip_top_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       rvalid;
  logic [7:0] rdata;

  modport master (
    output valid, data,
    input  ready, rvalid, rdata
  );
  modport slave (
    input  valid, data,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/chip_top_spi_master.sv
// SPI mode-0 master: one byte out on mosi, one byte in from miso.
module spi_master
  import chip_top_pkg::*;
#(
  parameter int SPI_HALF = DEF_SPI_HALF
) (
  input  logic       clk,
  input  logic       rst_n,
  chip_top_if.slave  bus,
  output logic       o_cs,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso
);
  localparam logic [7:0] HALF_M1 = 8'(SPI_HALF - 1);

  spi_state_e r_state, w_next;
  logic [7:0] r_cnt;
  logic [6:0] r_tx_sh;
  logic [7:0] r_rx_sh;
  logic [2:0] r_bit;
  logic       r_cs, r_sclk, r_mosi;
  logic       w_tick;

  assign w_tick     = (r_cnt == HALF_M1);
  assign bus.ready  = (r_state == SPI_IDLE);
  assign bus.rvalid = (r_state == SPI_HOLD) && w_tick;
  assign bus.rdata  = r_rx_sh;
  assign o_cs       = r_cs;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SPI_IDLE:  if (bus.valid) w_next = SPI_SETUP;
      SPI_SETUP: if (w_tick) w_next = SPI_SHIFT;
      SPI_SHIFT:
        if (w_tick && r_sclk && r_bit == 3'd7)
          w_next = SPI_HOLD;
      SPI_HOLD:  if (w_tick) w_next = SPI_GAP;
      SPI_GAP:   if (w_tick) w_next = SPI_IDLE;
      default:   w_next = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SPI_IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 3'd0;
      r_tx_sh <= 7'd0;
      r_rx_sh <= 8'd0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == SPI_IDLE || w_tick)
        r_cnt <= 8'd0;
      else
        r_cnt <= r_cnt + 8'd1;
      unique case (r_state)
        SPI_IDLE:
          if (bus.valid) begin
            r_tx_sh <= bus.data[6:0];
            r_mosi  <= bus.data[7];
            r_cs    <= 1'b0;
            r_bit   <= 3'd0;
          end
        SPI_SETUP:
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_rx_sh <= {r_rx_sh[6:0], i_miso};
          end
        SPI_SHIFT:
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              // mosi only moves on a falling edge, and not after the last bit
              if (r_bit != 3'd7) begin
                r_mosi  <= r_tx_sh[6];
                r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                r_bit   <= r_bit + 3'd1;
              end
            end else begin
              r_sclk  <= 1'b1;
              r_rx_sh <= {r_rx_sh[6:0], i_miso};
            end
          end
        SPI_HOLD: if (w_tick) r_cs <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/chip_top.sv
// UART-to-SPI bridge: each UART byte is exchanged over SPI and the
// returned byte is sent back on the UART.
module chip_top
  import chip_top_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int SPI_HALF    = DEF_SPI_HALF
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst_top,
  input  logic rxd,
  output logic txd,
  output logic spi_cs,
  output logic spi_sclk,
  output logic spi_mosi,
  input  logic spi_miso
);
  localparam logic [15:0] BIT_M1  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);

  logic w_clk, w_unused_clk_n, w_rst_n;
  logic [1:0] r_rst_sync;
  assign w_clk          = clk_p;
  assign w_unused_clk_n = clk_n;
  assign w_rst_n        = r_rst_sync[1];

  always_ff @(posedge w_clk or negedge rst_top) begin
    if (!rst_top) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  chip_top_if w_bus ();

  // ---------------- UART RX ----------------
  logic [2:0]  r_rx_sync;
  rx_state_e   r_rx_st, w_rx_nx;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic        w_rx, w_rx_fall, w_rx_half, w_rx_end;
  logic        w_rx_samp, w_rx_done;

  // stage 2 is edge history behind the two synchronizer flops
  assign w_rx      = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
  assign w_rx_half = (r_rx_cnt == HALF_M1);
  assign w_rx_end  = (r_rx_cnt == BIT_M1);

  always_comb begin
    w_rx_nx   = r_rx_st;
    w_rx_samp = 1'b0;
    w_rx_done = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: if (w_rx_fall) w_rx_nx = RX_START;
      RX_START:
        if (w_rx_half) begin
          w_rx_samp = 1'b1;
          w_rx_nx   = w_rx ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (w_rx_end) begin
          w_rx_samp = 1'b1;
          if (r_rx_bit == 3'd7) w_rx_nx = RX_STOP;
        end
      RX_STOP:
        if (w_rx_end) begin
          w_rx_samp = 1'b1;
          w_rx_done = w_rx;
          w_rx_nx   = RX_IDLE;
        end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync <= 3'b111;
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= 16'd0;
      r_rx_bit  <= 3'd0;
      r_rx_sh   <= 8'd0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], rxd};
      r_rx_st   <= w_rx_nx;
      if (r_rx_st == RX_IDLE || w_rx_samp)
        r_rx_cnt <= 16'd0;
      else
        r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_st == RX_IDLE)
        r_rx_bit <= 3'd0;
      if (r_rx_st == RX_DATA && w_rx_samp) begin
        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end

  // ---------------- holders ----------------
  logic       r_rxh_full, r_txh_full;
  logic [7:0] r_rxh_data, r_txh_data;
  logic       w_spi_start, w_tx_go;
  tx_state_e  r_tx_st, w_tx_nx;

  assign w_spi_start = r_rxh_full & ~r_txh_full & w_bus.ready;
  assign w_tx_go     = (r_tx_st == TX_IDLE) & r_txh_full;
  assign w_bus.valid = w_spi_start;
  assign w_bus.data  = r_rxh_data;

  // a completing byte may refill the holder in the cycle SPI drains it
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rxh_full <= 1'b0;
      r_rxh_data <= 8'd0;
      r_txh_full <= 1'b0;
      r_txh_data <= 8'd0;
    end else begin
      if (w_rx_done && (!r_rxh_full || w_spi_start)) begin
        r_rxh_full <= 1'b1;
        r_rxh_data <= r_rx_sh;
      end else if (w_spi_start) begin
        r_rxh_full <= 1'b0;
      end
      if (w_bus.rvalid) begin
        r_txh_full <= 1'b1;
        r_txh_data <= w_bus.rdata;
      end else if (w_tx_go) begin
        r_txh_full <= 1'b0;
      end
    end
  end

  spi_master #(.SPI_HALF(SPI_HALF)) u_spi (
    .clk    (w_clk),
    .rst_n  (w_rst_n),
    .bus    (w_bus),
    .o_cs   (spi_cs),
    .o_sclk (spi_sclk),
    .o_mosi (spi_mosi),
    .i_miso (spi_miso)
  );

  // ---------------- UART TX ----------------
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        w_tx_end;

  assign w_tx_end = (r_tx_cnt == BIT_M1);
  assign txd = (r_tx_st == TX_START) ? 1'b0 :
               (r_tx_st == TX_DATA)  ? r_tx_sh[0] : 1'b1;

  always_comb begin
    w_tx_nx = r_tx_st;
    unique case (r_tx_st)
      TX_IDLE:  if (r_txh_full) w_tx_nx = TX_START;
      TX_START: if (w_tx_end) w_tx_nx = TX_DATA;
      TX_DATA:
        if (w_tx_end && r_tx_bit == 3'd7)
          w_tx_nx = TX_STOP;
      TX_STOP:  if (w_tx_end) w_tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= 8'd0;
    end else begin
      r_tx_st <= w_tx_nx;
      if (r_tx_st == TX_IDLE || w_tx_end)
        r_tx_cnt <= 16'd0;
      else
        r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_tx_go) begin
        r_tx_sh  <= r_txh_data;
        r_tx_bit <= 3'd0;
      end
      if (r_tx_st == TX_DATA && w_tx_end) begin
        r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
        r_tx_bit <= r_tx_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_chip_top.sv
// Scoreboard bench for chip_top: UART stimulus, SPI and UART monitors.
module tb_chip_top;
  localparam int CPB = 16;
  localparam int SH  = 2;

  logic clk_p = 1'b0;
  logic clk_n, rst_top, rxd, txd;
  logic spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic miso_tie = 1'b0;

  assign clk_n = ~clk_p;
  always #5 clk_p = ~clk_p;
  assign spi_miso = miso_tie ? 1'b1 : (!spi_cs ? spi_mosi : 1'b0);

  chip_top #(.CLK_PER_BIT(CPB), .SPI_HALF(SH)) dut (
    .clk_p    (clk_p),
    .clk_n    (clk_n),
    .rst_top  (rst_top),
    .rxd      (rxd),
    .txd      (txd),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  int checks = 0;
  int failures = 0;
  int cs_falls = 0;
  int txd_falls = 0;
  logic [7:0] q_mosi[$];
  logic [7:0] q_txd[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=frame required=none", nm);
  endtask

  always @(negedge spi_cs) cs_falls++;
  always @(negedge txd) txd_falls++;

  // SPI monitor: collects mosi at each sclk rise while cs is low
  initial forever begin
    logic [7:0] mb;
    logic [7:0] e;
    int n;
    @(negedge spi_cs);
    mb = 8'd0;
    n = 0;
    forever begin
      @(posedge spi_sclk or posedge spi_cs);
      if (spi_cs) break;
      #1;
      mb = {mb[6:0], spi_mosi};
      n++;
    end
    if (rst_top) begin
      if (q_mosi.size() == 0) unexpected("spi_frame");
      else begin
        e = q_mosi.pop_front();
        chk("spi_pulses", n, 8);
        chk("spi_mosi", int'(mb), int'(e));
      end
    end
  end

  // UART monitor: decodes frames on txd mid-bit
  initial forever begin
    logic [7:0] b;
    logic [7:0] e;
    logic s0, sp;
    @(negedge txd);
    if (rst_top) begin
      repeat (CPB / 2) @(negedge clk_p);
      s0 = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk_p);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk_p);
      sp = txd;
      if (q_txd.size() == 0) unexpected("txd_frame");
      else begin
        e = q_txd.pop_front();
        chk("txd_start", int'(s0), 0);
        chk("txd_data", int'(b), int'(e));
        chk("txd_stop", int'(sp), 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk_p);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk_p);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk_p);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk_p);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk_p);
  endtask

  // reference: SPI echoes the byte; miso tied high returns all ones
  task automatic expect_byte(input logic [7:0] b);
    q_mosi.push_back(b);
    q_txd.push_back(miso_tie ? 8'hFF : b);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q_mosi.size() != 0 || q_txd.size() != 0) && t < 4000) begin
      @(negedge clk_p);
      t++;
    end
    chk({nm, "_pending"}, q_mosi.size() + q_txd.size(), 0);
    q_mosi.delete();
    q_txd.delete();
    repeat (20) @(negedge clk_p);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0, rises, t;
    logic prev;
    logic [7:0] rb;
    rxd = 1'b1;
    rst_top = 1'b1;
    #1 rst_top = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_p);
      chk("reset_outputs", int'({txd, spi_cs, spi_sclk, spi_mosi}), 'b1100);
    end
    rst_top = 1'b1;
    repeat (10) @(negedge clk_p);

    c0 = cs_falls;
    expect_byte(8'hA5);
    send_byte(8'hA5, 1'b1);
    drain("a5");
    chk("a5_cs_count", cs_falls - c0, 1);

    miso_tie = 1'b1;
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    drain("tie1");
    miso_tie = 1'b0;

    c0 = cs_falls;
    f0 = txd_falls;
    @(negedge clk_p);
    rxd = 1'b0;
    repeat (6) @(negedge clk_p);
    rxd = 1'b1;
    repeat (300) @(negedge clk_p);
    chk("glitch_no_cs", cs_falls - c0, 0);
    chk("glitch_no_txd", txd_falls - f0, 0);

    c0 = cs_falls;
    send_byte(8'h5A, 1'b0);
    repeat (60) @(negedge clk_p);
    chk("framing_no_cs", cs_falls - c0, 0);
    expect_byte(8'h11);
    send_byte(8'h11, 1'b1);
    drain("after_framing");
    chk("framing_cs_count", cs_falls - c0, 1);

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      expect_byte(rb);
      send_byte(rb, 1'b1);
    end
    drain("rand_loop");
    miso_tie = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      expect_byte(rb);
      send_byte(rb, 1'b1);
    end
    drain("rand_tie");
    miso_tie = 1'b0;

    f0 = txd_falls;
    fork
      send_byte(8'h96, 1'b1);
    join_none
    rises = 0;
    prev = 1'b0;
    t = 0;
    while (rises < 4 && t < 1000) begin
      @(negedge clk_p);
      t++;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    chk("abort_4th_pulse", rises, 4);
    rst_top = 1'b0;
    #1;
    chk("abort_cs", int'(spi_cs), 1);
    chk("abort_sclk", int'(spi_sclk), 0);
    chk("abort_mosi", int'(spi_mosi), 0);
    repeat (5) @(negedge clk_p);
    rst_top = 1'b1;
    wait fork;
    c0 = cs_falls;
    repeat (400) @(negedge clk_p);
    chk("abort_no_txd", txd_falls - f0, 0);
    chk("abort_no_cs", cs_falls - c0, 0);
    chk("queues_empty", q_mosi.size() + q_txd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip_top.md
CHIP_TOP -- requirements
Module: chip_top

Interface
REQ-001 Parameter CLK_PER_BIT, default 1736, clk cycles per UART bit (115200 baud at 200 MHz); legal range 8..65535.
REQ-002 Parameter SPI_HALF, default 4, clk cycles per SPI sclk half-period; legal range 1..255.
REQ-003 clk_p  input  1  positive leg of the differential system clock, 200 MHz nominal; the one design clock.
REQ-004 clk_n  input  1  negative leg of the same clock; board-compatibility pin only, unused by logic.
REQ-005 rst_top  input  1  asynchronous, active-low reset.
REQ-006 rxd  input  1  UART receive, asynchronous, idle high.
REQ-007 txd  output  1  UART transmit, idle high.
REQ-008 spi_cs  output  1  SPI chip select, active low.
REQ-009 spi_sclk  output  1  SPI clock, mode 0, idle low.
REQ-010 spi_mosi  output  1  SPI master-out data, MSB first.
REQ-011 spi_miso  input  1  SPI master-in data.

Function
REQ-012 The block SHALL be a UART-to-SPI bridge: each byte received on rxd is shifted out on SPI, and the byte captured from spi_miso is transmitted on txd.
REQ-013 rxd SHALL pass through a 2-flop synchronizer; the UART RX FSM (IDLE, START, DATA, STOP) SHALL leave IDLE on the synchronized falling edge.
REQ-014 RX SHALL re-sample at CLK_PER_BIT/2 (integer division); a high sample returns to IDLE with no output (false start).
REQ-015 RX SHALL then sample 8 data bits LSB-first and the stop bit, each CLK_PER_BIT cycles apart.
REQ-016 A stop-bit sample of 0 (framing error) SHALL discard the byte; otherwise the byte loads a 1-entry RX holding register.
REQ-017 If the RX holding register is still full when a new valid byte completes, the new byte SHALL be dropped (overrun); the held byte is kept.
REQ-018 The SPI FSM (IDLE, SETUP, SHIFT, HOLD, GAP) SHALL start only when the RX holder is full and the TX holder is empty; the start consumes the RX holder.
REQ-019 SETUP: spi_cs=0 and spi_mosi=bit7 for SPI_HALF cycles.
REQ-020 SHIFT: 8 bits, each bit sclk high for SPI_HALF cycles then low for SPI_HALF cycles.
REQ-021 spi_miso SHALL be sampled on the clk cycle in which sclk rises.
REQ-022 spi_mosi SHALL change only on sclk falling edges.
REQ-023 HOLD: after the 8th falling edge, cs stays low SPI_HALF cycles; GAP: then cs=1 for at least SPI_HALF cycles before any next start.
REQ-024 At the end of HOLD the captured byte SHALL load the 1-entry TX holding register.
REQ-025 The UART TX FSM (IDLE, START, DATA, STOP) SHALL start the cycle after the TX holder fills: start bit 0, 8 bits LSB-first, stop bit 1, each CLK_PER_BIT cycles; the holder frees when the start bit begins.
REQ-026 Simultaneous RX completion and SPI start in one cycle SHALL be legal; the RX holder frees and refills in that cycle.

Reset
REQ-027 rst_top=0 SHALL immediately force txd=1, spi_cs=1, spi_sclk=0, spi_mosi=0, all FSMs IDLE, both holders empty.
REQ-028 Reset deassertion SHALL pass through a 2-flop synchronizer (async assert, sync release).
REQ-029 Reset mid-transfer SHALL abort the transfer with no partial byte retained.

Structure
REQ-030 Package chip_top_pkg SHALL hold the RX/TX/SPI state enums and default CLK_PER_BIT/SPI_HALF constants.
REQ-031 One sub-module, spi_master (byte shifter plus SPI FSM), SHALL be used; UART RX/TX are inline; target 150-350 RTL lines.

Verification
REQ-032 All scenarios SHALL run with CLK_PER_BIT=16, SPI_HALF=2, and spi_miso looped to spi_mosi while spi_cs=0, except where stated.
REQ-033 Reset: rst_top low 130 ns -> txd=1, spi_cs=1, spi_sclk=0, spi_mosi=0 throughout.
REQ-034 Send 0xA5 -> exactly 8 sclk pulses, mosi 1,0,1,0,0,1,0,1 -> txd returns frame 0xA5.
REQ-035 Same, spi_miso tied 1 -> mosi 0x3C gives txd frame 0xFF.
REQ-036 rxd low pulse of 6 cycles -> no cs assertion, txd stays 1.
REQ-037 Frame 0x5A with stop bit 0 -> no SPI activity; a following good 0x11 -> txd returns 0x11.
REQ-038 rst_top low during the 4th sclk pulse -> cs=1, sclk=0 same cycle; after release, no txd frame.
